// File: rtl/pipeline_pkg.sv
// Shared types and constants for the dot-product pipeline initiator.
package pipeline_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_LAT   = 2;
  localparam int DEF_SET_W = 4 * DEF_W;

  typedef struct packed {
    logic [DEF_W-1:0] a1;
    logic [DEF_W-1:0] b1;
    logic [DEF_W-1:0] a2;
    logic [DEF_W-1:0] b2;
  } operand_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head data is read straight from storage.
module sync_fifo
  import pipeline_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DW-1:0]           din,
  output logic [DW-1:0]           dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when the head leaves at the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pipeline_driver.sv
// Feeds operand sets into a fixed-latency dot-product pipeline and returns results
// in order, using credits so the result FIFO can never overflow.
module pipeline_driver
  import pipeline_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int LAT       = DEF_LAT,
  parameter int IN_DEPTH  = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a1,
  input  logic [W-1:0] in_b1,
  input  logic [W-1:0] in_a2,
  input  logic [W-1:0] in_b2,
  output logic [W-1:0] pipe_a1,
  output logic [W-1:0] pipe_b1,
  output logic [W-1:0] pipe_a2,
  output logic [W-1:0] pipe_b2,
  input  logic [W-1:0] pipe_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic         busy
);

  localparam int SET_W = 4 * W;
  localparam int IAW   = clog2(IN_DEPTH);
  localparam int RAW   = clog2(RES_DEPTH);
  localparam int CW    = RAW + 1;

  logic             running;
  logic             in_push;
  logic             in_full;
  logic             in_empty;
  logic [IAW:0]     in_count;
  logic [SET_W-1:0] in_head;
  logic             res_push;
  logic             res_pop;
  logic             res_full;
  logic             res_empty;
  logic [RAW:0]     res_count;
  logic [LAT-1:0]   tracker;
  logic [CW-1:0]    credits;
  logic             issue;

  // Both streams: a transfer happens at a posedge where valid and ready are both 1;
  // valid never waits on ready, and payload is stable while valid is held.
  assign in_ready  = running && !in_full;
  assign in_push   = in_valid && in_ready;
  assign issue     = !in_empty && (credits != '0);
  assign res_push  = tracker[LAT-1];
  assign out_valid = !res_empty;
  assign res_pop   = out_valid && out_ready;
  assign busy      = (in_count != '0) || (tracker != '0) || (res_count != '0);

  sync_fifo #(.DW(SET_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_push),
    .pop   (issue),
    .din   ({in_a1, in_b1, in_a2, in_b2}),
    .dout  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  sync_fifo #(.DW(W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_push),
    .pop   (res_pop),
    .din   (pipe_c),
    .dout  (out_c),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running <= 1'b0;
      tracker <= '0;
      credits <= CW'(RES_DEPTH);
      pipe_a1 <= '0;
      pipe_b1 <= '0;
      pipe_a2 <= '0;
      pipe_b2 <= '0;
    end else begin
      running <= 1'b1;
      tracker <= (tracker << 1) | LAT'(issue);
      if (issue) begin
        {pipe_a1, pipe_b1, pipe_a2, pipe_b2} <= in_head;
      end else begin
        {pipe_a1, pipe_b1, pipe_a2, pipe_b2} <= '0;
      end
      // A credit is held from issue until the result leaves the result FIFO.
      case ({issue, res_pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  a_res_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(res_push && res_full && !res_pop));

endmodule

// File: tb/tb_pipeline_driver.sv
// Directed and randomised checks of pipeline_driver against a queue-based model.
module tb_pipeline_driver;
  import pipeline_pkg::*;

  localparam int W         = DEF_W;
  localparam int LAT       = DEF_LAT;
  localparam int IN_DEPTH  = 4;
  localparam int RES_DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a1, in_b1, in_a2, in_b2;
  logic [W-1:0] pipe_a1, pipe_b1, pipe_a2, pipe_b2;
  logic [W-1:0] pipe_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_driver #(.W(W), .LAT(LAT), .IN_DEPTH(IN_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a1     (in_a1),
    .in_b1     (in_b1),
    .in_a2     (in_a2),
    .in_b2     (in_b2),
    .pipe_a1   (pipe_a1),
    .pipe_b1   (pipe_b1),
    .pipe_a2   (pipe_a2),
    .pipe_b2   (pipe_b2),
    .pipe_c    (pipe_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external pipeline: C valid at the LAT-th edge after issue ----------------
  logic [W-1:0] stg [LAT-1];
  always @(posedge clk) begin
    stg[0] <= pipe_a1 * pipe_b1 + pipe_a2 * pipe_b2;
    for (int i = 1; i < LAT - 1; i++) stg[i] <= stg[i-1];
  end
  assign pipe_c = stg[LAT-2];

  function automatic logic [W-1:0] dot(input operand_t s);
    return s.a1 * s.b1 + s.a2 * s.b2;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  operand_t     m_op_q[$];
  logic [W-1:0] m_fl_c[$];
  int           m_fl_t[$];
  logic [W-1:0] m_res_q[$];
  bit           m_run  = 1'b0;
  bit           chk_en = 1'b0;
  int           m_cyc  = 0;
  operand_t     exp_pipe;

  initial begin
    forever begin
      @(posedge clk);
      m_cyc++;
      if (!rst_n) begin
        m_op_q.delete();
        m_fl_c.delete();
        m_fl_t.delete();
        m_res_q.delete();
        m_run    = 1'b0;
        exp_pipe = '0;
        chk_en   = 1'b1;
      end else begin
        bit acc, pop, iss;
        int cred;
        operand_t s;
        acc  = in_valid && m_run && (m_op_q.size() < IN_DEPTH);
        pop  = out_ready && (m_res_q.size() > 0);
        cred = RES_DEPTH - m_fl_c.size() - m_res_q.size();
        iss  = (m_op_q.size() > 0) && (cred > 0);
        if (pop) void'(m_res_q.pop_front());
        if (m_fl_t.size() > 0 && (m_cyc - m_fl_t[0]) == LAT) begin
          m_res_q.push_back(m_fl_c.pop_front());
          void'(m_fl_t.pop_front());
        end
        if (iss) begin
          s = m_op_q.pop_front();
          exp_pipe = s;
          m_fl_c.push_back(dot(s));
          m_fl_t.push_back(m_cyc);
        end else begin
          exp_pipe = '0;
        end
        if (acc) begin
          s.a1 = in_a1; s.b1 = in_b1; s.a2 = in_a2; s.b2 = in_b2;
          m_op_q.push_back(s);
        end
        m_run = 1'b1;
      end
    end
  end

  // ---------------- result monitor ----------------
  logic [W-1:0] got_q[$];
  int           got_t[$];
  int           mon_cyc = 0;
  int           obs_iss = 0;
  int           obs_pop = 0;

  initial begin
    forever begin
      @(posedge clk);
      mon_cyc++;
      if (!rst_n) begin
        obs_iss = 0;
        obs_pop = 0;
      end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_q.push_back(out_c);
        got_t.push_back(mon_cyc);
        obs_pop++;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (|{pipe_a1, pipe_b1, pipe_a2, pipe_b2}) obs_iss++;
        chk("m_in_ready",  W'(in_ready),  W'(m_run && (m_op_q.size() < IN_DEPTH)));
        chk("m_out_valid", W'(out_valid), W'(m_res_q.size() > 0));
        chk("m_busy",      W'(busy),
            W'((m_op_q.size() + m_fl_c.size() + m_res_q.size()) > 0));
        chk("m_pipe_a1", pipe_a1, exp_pipe.a1);
        chk("m_pipe_b1", pipe_b1, exp_pipe.b1);
        chk("m_pipe_a2", pipe_a2, exp_pipe.a2);
        chk("m_pipe_b2", pipe_b2, exp_pipe.b2);
        if (m_res_q.size() > 0) chk("m_out_c", out_c, m_res_q[0]);
        chk("outstanding_le_depth", W'((obs_iss - obs_pop) <= RES_DEPTH), W'(1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a1, b1, a2, b2);
    bit acc;
    int k;
    k = 0;
    in_valid = 1'b1;
    in_a1 = a1; in_b1 = b1; in_a2 = a2; in_b2 = b2;
    forever begin
      @(posedge clk);
      acc = in_ready;
      #1;
      k++;
      if (acc) break;
      if (k > 200) begin
        chk("send_timeout", W'(0), W'(1));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_got(input int n, input int limit, input string nm);
    int k;
    k = 0;
    while (got_q.size() < n && k < limit) begin
      tick(1);
      k++;
    end
    chk(nm, W'(got_q.size()), W'(n));
  endtask

  task automatic chk_pipe(input string nm, input logic [W-1:0] a1, b1, a2, b2);
    chk({nm, "_a1"}, pipe_a1, a1);
    chk({nm, "_b1"}, pipe_b1, b1);
    chk({nm, "_a2"}, pipe_a2, a2);
    chk({nm, "_b2"}, pipe_b2, b2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  logic [W-1:0] t3_exp [8] = '{32'd14, 32'd26, 32'd42, 32'd62, 32'd86, 32'd114, 32'd146, 32'd182};
  logic [W-1:0] exp_q[$];
  logic [W-1:0] a1_seen[$];
  int           k_seen[$];
  bit           rnd_on;
  int           base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a1 = '0; in_b1 = '0; in_a2 = '0; in_b2 = '0;
    tick(2);
    chk_pipe("rst_pipe", '0, '0, '0, '0);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy",      W'(busy),      W'(0));
    chk("rst_in_ready",  W'(in_ready),  W'(0));
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_in_ready", W'(in_ready), W'(1));

    // 1: single set, 1 + LAT + 1 edges to out_valid
    out_ready = 1'b1;
    got_q.delete(); got_t.delete();
    send(0, 1, 2, 3);
    chk_pipe("t1_bypass", '0, '0, '0, '0);
    tick(1);
    chk_pipe("t1_pipe", 0, 1, 2, 3);
    tick(1);
    chk("t1_out_valid_early", W'(out_valid), W'(0));
    tick(1);
    chk("t1_out_valid", W'(out_valid), W'(1));
    chk("t1_out_c", out_c, 6);
    chk("t1_busy_hi", W'(busy), W'(1));
    tick(1);
    chk("t1_busy_lo", W'(busy), W'(0));

    // 2: back-to-back sets leave on consecutive cycles
    got_q.delete(); got_t.delete();
    send(0, 1, 2, 3);
    send(3, 2, 1, 0);
    send(1, 1, 1, 1);
    wait_got(3, 30, "t2_count");
    if (got_q.size() == 3) begin
      chk("t2_c0", got_q[0], 6);
      chk("t2_c1", got_q[1], 6);
      chk("t2_c2", got_q[2], 2);
      chk("t2_gap01", W'(got_t[1] - got_t[0]), 1);
      chk("t2_gap12", W'(got_t[2] - got_t[1]), 1);
    end
    tick(3);

    // 3: consumer stalled: only RES_DEPTH issued, then operand FIFO fills
    out_ready = 1'b0;
    got_q.delete(); got_t.delete();
    base = obs_iss;
    for (int i = 0; i < 8; i++) send(i + 1, i + 2, i + 3, i + 4);
    tick(3);
    chk("t3_in_ready_lo", W'(in_ready), W'(0));
    chk("t3_issued", W'(obs_iss - base), W'(RES_DEPTH));
    chk("t3_out_valid", W'(out_valid), W'(1));
    chk("t3_none_popped", W'(got_q.size()), W'(0));

    // 4: releasing the consumer lets the queued sets issue with no bubble
    out_ready = 1'b1;
    a1_seen.delete(); k_seen.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pipe_a1 != '0) begin
        a1_seen.push_back(pipe_a1);
        k_seen.push_back(k);
      end
    end
    #1;
    chk("t4_issue_count", W'(a1_seen.size()), W'(4));
    if (a1_seen.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("t4_issue_a1", a1_seen[j], W'(5 + j));
        chk("t4_no_bubble", W'(k_seen[j] - k_seen[0]), W'(j));
      end
    end
    wait_got(8, 40, "t3_count");
    if (got_q.size() == 8) begin
      for (int j = 0; j < 8; j++) chk("t3_order", got_q[j], t3_exp[j]);
    end
    tick(3);

    // 5: reset with two sets in flight discards them
    send(1, 1, 1, 1);
    send(1, 2, 1, 2);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk_pipe("t5_pipe", '0, '0, '0, '0);
    chk("t5_out_valid", W'(out_valid), W'(0));
    chk("t5_busy",      W'(busy),      W'(0));
    rst_n = 1'b1;
    got_q.delete(); got_t.delete();
    send(2, 2, 2, 2);
    wait_got(1, 20, "t5_count");
    if (got_q.size() > 0) chk("t5_out_c", got_q[0], 8);
    tick(5);
    chk("t5_no_stale", W'(got_q.size()), W'(1));

    // 6: random data, random gaps, random consumer stalls
    got_q.delete(); got_t.delete();
    exp_q.delete();
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          operand_t s;
          s.a1 = $urandom() | 32'd1;
          s.b1 = $urandom();
          s.a2 = $urandom();
          s.b2 = $urandom();
          exp_q.push_back(dot(s));
          send(s.a1, s.b1, s.a2, s.b2);
          tick($urandom_range(0, 2));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_got(20, 60, "t6_count");
    if (got_q.size() == 20) begin
      for (int j = 0; j < 20; j++) chk("t6_scoreboard", got_q[j], exp_q[j]);
    end
    tick(3);
    chk("t6_idle", W'(busy), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
